rv32_decoder: RTL and testbench
===============================

# rv32_decoder

Registered RV32I instruction decode stage, the inverse of the team's instruction-encoding helpers. It accepts a 32-bit instruction word and its PC from fetch over a valid/ready handshake. It splits the word into register indices, a sign-extended immediate, a class code and write-enable/illegal flags, and presents them one cycle later over a valid/ready handshake to execute. It holds one entry and supports a pipeline flush.

## Interface
Parameters:
- none; fixed at RV32I, XLEN=32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstz  in  1  asynchronous, active-low reset.
- flush  in  1  discard held entry and block intake this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of in_instr.
- in_valid  in  1  fetch offers in_instr/in_pc.
- in_ready  out  1  stage accepts this cycle.
- dec_pc  out  32  registered PC.
- dec_rd / dec_rs1 / dec_rs2  out  5 each  instr[11:7] / [19:15] / [24:20], raw.
- dec_funct3  out  3  instr[14:12].
- dec_sub  out  1  instr[30] for OP and for OPIMM funct3=101; else 0.
- dec_imm  out  32  decoded immediate.
- dec_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 15 ILLEGAL.
- dec_rd_we  out  1  instruction writes a nonzero rd.
- dec_illegal  out  1  word not a legal RV32I (subset) encoding.
- dec_valid  out  1  outputs hold a decoded instruction.
- dec_ready  in  1  execute consumes this cycle.

## Operation
- in_ready = ~flush & (~dec_valid | dec_ready), combinational.
- Load: when in_valid & in_ready, all dec_* fields capture the decode of in_instr/in_pc and dec_valid is set.
- Consume without new load: dec_valid clears. Fields are don't-care but hold their values.
- Stall: while dec_valid & ~dec_ready, every dec_* output is held bit-stable.
- flush: dec_valid clears next edge regardless of dec_ready. No load occurs that cycle.
- Immediate selection by class:
  - I-type (JALR, LOAD, OPIMM): sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - U: {instr[31:12],12'h000}.
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - OP and ILLEGAL: 0.
- Illegal when any of the following holds:
  - instr[1:0]≠11, or opcode not one of the nine classes.
  - JALR funct3≠000.
  - BRANCH funct3 ∈ {010,011}.
  - LOAD funct3 ∈ {011,110,111}.
  - STORE funct3 ≥ 011.
  - OPIMM funct3=001 and instr[31:25]≠0.
  - OPIMM funct3=101 and instr[31:25] ∉ {0000000,0100000}.
  - OP with instr[31:25]=0100000 and funct3 ∉ {000,101}.
  - OP with instr[31:25] ∉ {0000000,0100000}.
- When illegal: dec_class=15, dec_illegal=1, dec_rd_we=0, dec_sub=0. Register fields are raw.
- dec_rd_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP when rd≠0. BRANCH, STORE and ILLEGAL always give 0.
- Illegal entries still flow through the handshake; no stall or exception is raised here.

## Timing
- Reset (rstz low, async): dec_valid=0 and every dec_* output=0, so dec_class=0. in_ready reads 1 unless flush is high.
- Latency: 1 cycle from accept edge to dec_valid high.
- Throughput: 1 instruction/cycle with dec_ready held high. Load and consume occur on the same edge.
- Simultaneous flush & dec_ready: flush wins; dec_valid=0 next cycle.
- Simultaneous flush & in_valid: the input is not accepted (in_ready=0). Fetch must re-present or drop it.
- rstz asserted mid-stall clears dec_valid immediately; the held entry is lost.
- No combinational path from in_instr to any dec_* output.

## Test plan
- addi x1,x2,-1 (0xFFF10093) accepted → next cycle class 7, rd 1, rs1 2, imm 0xFFFFFFFF, rd_we 1.
- beq x1,x2,-4 (0xFE208EE3), lui x5,0x12345 (0x123452B7) and jal x1,2048 (0x001000EF) back-to-back with dec_ready=1 → three consecutive valid cycles:
  - class 4, imm 0xFFFFFFFC, rd_we 0.
  - class 1→0 (LUI=0), imm 0x12345000, rd 5.
  - class 2, imm 0x00000800.
- 0x00000000 and sub-with-funct3=001 (0x402091B3) → class 15, illegal 1, rd_we 0. sub x3,x1,x2 (0x402081B3) → class 8, sub 1, rd_we 1.
- dec_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs bit-stable. Release gives the held entry, then the next one, with no loss or duplication.
- flush asserted while dec_valid=1 and in_valid=1 → dec_valid=0 next cycle and that input is not captured.
- rstz pulsed low while a stalled entry is held → outputs 0 immediately. in_ready=1 after release.

Source files
------------

// File: rtl/rv32_decoder.sv
// RV32I decode stage: one registered entry between fetch and execute.
// Splits the instruction word into fields, immediate, class and flags.
module rv32_decoder (
  input  logic        clk,
  input  logic        rstz,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] dec_pc,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [2:0]  dec_funct3,
  output logic        dec_sub,
  output logic [31:0] dec_imm,
  output logic [3:0]  dec_class,
  output logic        dec_rd_we,
  output logic        dec_illegal,
  output logic        dec_valid,
  input  logic        dec_ready
);

  localparam logic [3:0] C_LUI   = 4'd0;
  localparam logic [3:0] C_AUIPC = 4'd1;
  localparam logic [3:0] C_JAL   = 4'd2;
  localparam logic [3:0] C_JALR  = 4'd3;
  localparam logic [3:0] C_BR    = 4'd4;
  localparam logic [3:0] C_LOAD  = 4'd5;
  localparam logic [3:0] C_STORE = 4'd6;
  localparam logic [3:0] C_OPIMM = 4'd7;
  localparam logic [3:0] C_OP    = 4'd8;
  localparam logic [3:0] C_ILL   = 4'd15;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [3:0]  cls_raw;
  logic        ill;
  logic [3:0]  cls;
  logic [31:0] imm;
  logic        sub;
  logic        we;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic        load;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // Full 7-bit opcode match also rejects instr[1:0] != 2'b11.
  always_comb begin
    cls_raw = C_ILL;
    ill = 1'b0;
    case (op)
      7'b0110111: cls_raw = C_LUI;
      7'b0010111: cls_raw = C_AUIPC;
      7'b1101111: cls_raw = C_JAL;
      7'b1100111: begin
        cls_raw = C_JALR;
        ill = (f3 != 3'b000);
      end
      7'b1100011: begin
        cls_raw = C_BR;
        ill = (f3[2:1] == 2'b01);
      end
      7'b0000011: begin
        cls_raw = C_LOAD;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      7'b0100011: begin
        cls_raw = C_STORE;
        ill = (f3 >= 3'b011);
      end
      7'b0010011: begin
        cls_raw = C_OPIMM;
        ill = ((f3 == 3'b001) && (f7 != 7'h00))
           || ((f3 == 3'b101) && (f7 != 7'h00)
               && (f7 != 7'h20));
      end
      7'b0110011: begin
        cls_raw = C_OP;
        ill = ((f7 == 7'h20) && (f3 != 3'b000)
               && (f3 != 3'b101))
           || ((f7 != 7'h00) && (f7 != 7'h20));
      end
      default: ill = 1'b1;
    endcase
  end

  assign cls  = ill ? C_ILL : cls_raw;
  assign is_i = (cls == C_JALR) || (cls == C_LOAD)
             || (cls == C_OPIMM);
  assign is_s = (cls == C_STORE);
  assign is_b = (cls == C_BR);
  assign is_u = (cls == C_LUI) || (cls == C_AUIPC);
  assign is_j = (cls == C_JAL);

  always_comb begin
    imm = 32'h0;
    unique case (1'b1)
      is_i: imm = {{20{in_instr[31]}}, in_instr[31:20]};
      is_s: imm = {{20{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
      is_b: imm = {{19{in_instr[31]}}, in_instr[31],
                   in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      is_u: imm = {in_instr[31:12], 12'h000};
      is_j: imm = {{11{in_instr[31]}}, in_instr[31],
                   in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  assign sub = ((cls == C_OP)
             || ((cls == C_OPIMM) && (f3 == 3'b101)))
             && in_instr[30];

  assign we = (in_instr[11:7] != 5'd0)
           && (cls != C_BR) && (cls != C_STORE)
           && (cls != C_ILL);

  assign in_ready = ~flush & (~dec_valid | dec_ready);
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      dec_valid   <= 1'b0;
      dec_pc      <= 32'h0;
      dec_rd      <= 5'd0;
      dec_rs1     <= 5'd0;
      dec_rs2     <= 5'd0;
      dec_funct3  <= 3'd0;
      dec_sub     <= 1'b0;
      dec_imm     <= 32'h0;
      dec_class   <= 4'd0;
      dec_rd_we   <= 1'b0;
      dec_illegal <= 1'b0;
    end else begin
      if (load) begin
        dec_valid   <= 1'b1;
        dec_pc      <= in_pc;
        dec_rd      <= in_instr[11:7];
        dec_rs1     <= in_instr[19:15];
        dec_rs2     <= in_instr[24:20];
        dec_funct3  <= f3;
        dec_sub     <= sub;
        dec_imm     <= imm;
        dec_class   <= cls;
        dec_rd_we   <= we;
        dec_illegal <= ill;
      end else if (flush || dec_ready) begin
        dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_decoder.sv
// Directed bench for rv32_decoder: field decode, handshake,
// stall, flush and asynchronous reset behaviour.
module tb_rv32_decoder;

  logic        clk;
  logic        rstz;
  logic        flush;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dec_pc;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [2:0]  dec_funct3;
  logic        dec_sub;
  logic [31:0] dec_imm;
  logic [3:0]  dec_class;
  logic        dec_rd_we;
  logic        dec_illegal;
  logic        dec_valid;
  logic        dec_ready;

  int ncmp;
  int nbad;

  rv32_decoder dut (
    .clk        (clk),
    .rstz       (rstz),
    .flush      (flush),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dec_pc     (dec_pc),
    .dec_rd     (dec_rd),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_funct3 (dec_funct3),
    .dec_sub    (dec_sub),
    .dec_imm    (dec_imm),
    .dec_class  (dec_class),
    .dec_rd_we  (dec_rd_we),
    .dec_illegal(dec_illegal),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i,
                       input logic [31:0] p);
    in_instr = i;
    in_pc    = p;
    in_valid = 1'b1;
  endtask

  initial begin
    ncmp = 0;
    nbad = 0;
    rstz = 1'b0;
    flush = 1'b0;
    in_instr = 32'h0;
    in_pc = 32'h0;
    in_valid = 1'b0;
    dec_ready = 1'b1;
    #3;
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_class", {28'd0, dec_class}, 32'd0);
    chk("rst_imm", dec_imm, 32'h0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    rstz = 1'b1;

    // addi x1,x2,-1
    offer(32'hFFF10093, 32'h100);
    step();
    in_valid = 1'b0;
    chk("addi_v", {31'd0, dec_valid}, 32'd1);
    chk("addi_cls", {28'd0, dec_class}, 32'd7);
    chk("addi_rd", {27'd0, dec_rd}, 32'd1);
    chk("addi_rs1", {27'd0, dec_rs1}, 32'd2);
    chk("addi_imm", dec_imm, 32'hFFFFFFFF);
    chk("addi_we", {31'd0, dec_rd_we}, 32'd1);
    chk("addi_pc", dec_pc, 32'h100);
    chk("addi_ill", {31'd0, dec_illegal}, 32'd0);
    step();
    chk("addi_drain", {31'd0, dec_valid}, 32'd0);

    // beq / lui / jal back to back
    offer(32'hFE208EE3, 32'h104);
    step();
    chk("beq_v", {31'd0, dec_valid}, 32'd1);
    chk("beq_cls", {28'd0, dec_class}, 32'd4);
    chk("beq_imm", dec_imm, 32'hFFFFFFFC);
    chk("beq_we", {31'd0, dec_rd_we}, 32'd0);
    offer(32'h123452B7, 32'h108);
    chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("lui_v", {31'd0, dec_valid}, 32'd1);
    chk("lui_cls", {28'd0, dec_class}, 32'd0);
    chk("lui_imm", dec_imm, 32'h12345000);
    chk("lui_rd", {27'd0, dec_rd}, 32'd5);
    chk("lui_we", {31'd0, dec_rd_we}, 32'd1);
    offer(32'h001000EF, 32'h10C);
    step();
    chk("jal_v", {31'd0, dec_valid}, 32'd1);
    chk("jal_cls", {28'd0, dec_class}, 32'd2);
    chk("jal_imm", dec_imm, 32'h00000800);
    chk("jal_pc", dec_pc, 32'h10C);
    in_valid = 1'b0;
    step();
    chk("jal_drain", {31'd0, dec_valid}, 32'd0);

    // illegal words and sub
    offer(32'h00000000, 32'h200);
    step();
    chk("zero_cls", {28'd0, dec_class}, 32'd15);
    chk("zero_ill", {31'd0, dec_illegal}, 32'd1);
    chk("zero_we", {31'd0, dec_rd_we}, 32'd0);
    offer(32'h402091B3, 32'h204);
    step();
    chk("subf3_cls", {28'd0, dec_class}, 32'd15);
    chk("subf3_ill", {31'd0, dec_illegal}, 32'd1);
    chk("subf3_we", {31'd0, dec_rd_we}, 32'd0);
    chk("subf3_sub", {31'd0, dec_sub}, 32'd0);
    chk("subf3_rd", {27'd0, dec_rd}, 32'd3);
    offer(32'h402081B3, 32'h208);
    step();
    chk("sub_cls", {28'd0, dec_class}, 32'd8);
    chk("sub_sub", {31'd0, dec_sub}, 32'd1);
    chk("sub_we", {31'd0, dec_rd_we}, 32'd1);
    chk("sub_ill", {31'd0, dec_illegal}, 32'd0);
    chk("sub_imm", dec_imm, 32'h0);
    chk("sub_rs2", {27'd0, dec_rs2}, 32'd2);
    offer(32'h0020B023, 32'h20C);
    step();
    chk("sw3_cls", {28'd0, dec_class}, 32'd15);
    in_valid = 1'b0;
    step();

    // stall: hold A for three cycles while B waits
    dec_ready = 1'b0;
    offer(32'hFFF10093, 32'h300);
    step();
    offer(32'h123452B7, 32'h304);
    for (int k = 0; k < 3; k++) begin
      chk("stl_rdy", {31'd0, in_ready}, 32'd0);
      chk("stl_v", {31'd0, dec_valid}, 32'd1);
      chk("stl_pc", dec_pc, 32'h300);
      chk("stl_imm", dec_imm, 32'hFFFFFFFF);
      chk("stl_cls", {28'd0, dec_class}, 32'd7);
      step();
    end
    dec_ready = 1'b1;
    #1;
    chk("rel_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("rel_v", {31'd0, dec_valid}, 32'd1);
    chk("rel_pc", dec_pc, 32'h304);
    chk("rel_cls", {28'd0, dec_class}, 32'd0);
    step();
    chk("rel_nodup", {31'd0, dec_valid}, 32'd0);

    // flush with a held entry and a pending input
    dec_ready = 1'b0;
    offer(32'hFFF10093, 32'h400);
    step();
    offer(32'h123452B7, 32'h404);
    flush = 1'b1;
    dec_ready = 1'b1;
    #1;
    chk("fl_rdy", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_v", {31'd0, dec_valid}, 32'd0);
    chk("fl_pc", dec_pc, 32'h400);

    // async reset during a stall
    dec_ready = 1'b0;
    offer(32'h123452B7, 32'h500);
    step();
    in_valid = 1'b0;
    chk("ar_v0", {31'd0, dec_valid}, 32'd1);
    rstz = 1'b0;
    #1;
    chk("ar_v", {31'd0, dec_valid}, 32'd0);
    chk("ar_pc", dec_pc, 32'h0);
    chk("ar_imm", dec_imm, 32'h0);
    chk("ar_rd", {27'd0, dec_rd}, 32'd0);
    chk("ar_we", {31'd0, dec_rd_we}, 32'd0);
    rstz = 1'b1;
    #1;
    chk("ar_rdy", {31'd0, in_ready}, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
